// File: rtl/md_audio_pkg.sv
// Shared types and helpers for the N-channel stereo audio mixer.
// Holds the sequencer state encoding and the signed saturation helper.
package md_audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        SAT  = 2'd2
    } state_t;

    localparam int DEF_GAIN_FRAC = 6;
    localparam int UNITY         = 1 << DEF_GAIN_FRAC;

    // Clamp a sign-extended value into a signed field of 'width' bits.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                                 input int                 width);
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        v_max = (64'sd1 <<< (width - 1)) - 64'sd1;
        v_min = -(64'sd1 <<< (width - 1));
        if (value > v_max)
            sat_s = v_max;
        else if (value < v_min)
            sat_s = v_min;
        else
            sat_s = value;
    endfunction

endpackage

// File: rtl/md_audio_mix_if.sv
// Sample, config, and output bundle between the audio sources and the mixer.
// master = source/controller side, slave = the mixer itself.
interface md_audio_mix_if #(
    parameter int N_CH   = 4,
    parameter int IN_W   = 10,
    parameter int GAIN_W = 8,
    parameter int OUT_W  = 16,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH*IN_W-1:0]     ch_data;
    logic [N_CH-1:0]          ch_valid;
    logic [N_CH-1:0]          ch_unsigned;
    logic                     tick;
    logic                     cfg_we;
    logic [CH_W-1:0]          cfg_ch;
    logic [GAIN_W-1:0]        cfg_gain;
    logic [1:0]               cfg_pan;
    logic                     cfg_ready;
    logic                     flag_clr;
    logic signed [OUT_W-1:0]  out_l;
    logic signed [OUT_W-1:0]  out_r;
    logic                     out_valid;
    logic                     busy;
    logic                     clip;
    logic                     overrun;

    modport master (
        output ch_data, ch_valid, ch_unsigned, tick,
        output cfg_we, cfg_ch, cfg_gain, cfg_pan, flag_clr,
        input  cfg_ready, out_l, out_r, out_valid, busy, clip, overrun
    );

    modport slave (
        input  ch_data, ch_valid, ch_unsigned, tick,
        input  cfg_we, cfg_ch, cfg_gain, cfg_pan, flag_clr,
        output cfg_ready, out_l, out_r, out_valid, busy, clip, overrun
    );
endinterface

// File: rtl/md_audio_mac.sv
// Shared multiply-accumulate for the mixer: signed sample x unsigned gain,
// added into the left and/or right accumulator according to the pan bits.
module md_audio_mac #(
    parameter int IN_W   = 10,
    parameter int GAIN_W = 8,
    parameter int ACC_W  = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [IN_W-1:0]  i_sample,
    input  logic [GAIN_W-1:0]       i_gain,
    input  logic [1:0]              i_pan,
    output logic signed [ACC_W-1:0] o_acc_l,
    output logic signed [ACC_W-1:0] o_acc_r
);
    localparam int PROD_W = IN_W + GAIN_W + 1;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  r_acc_l;
    logic signed [ACC_W-1:0]  r_acc_r;

    // Zero-extend the gain so the product stays a signed x unsigned multiply.
    assign w_prod     = PROD_W'(i_sample) * PROD_W'($signed({1'b0, i_gain}));
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_l <= '0;
            r_acc_r <= '0;
        end else if (i_clr) begin
            r_acc_l <= '0;
            r_acc_r <= '0;
        end else if (i_en) begin
            if (i_pan[0])
                r_acc_l <= r_acc_l + w_prod_ext;
            if (i_pan[1])
                r_acc_r <= r_acc_r + w_prod_ext;
        end
    end

    assign o_acc_l = r_acc_l;
    assign o_acc_r = r_acc_r;
endmodule

// File: rtl/md_audio_mix.sv
// N-channel stereo mixer: holds latest samples, applies per-channel gain/pan
// over one shared MAC on each tick, saturates, and flags clip/overrun.
//   state | meaning
//   IDLE  | waiting for tick; config writes accepted
//   SUM   | one channel per cycle through the MAC
//   SAT   | scale, clamp, register outputs
module md_audio_mix
    import md_audio_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int IN_W      = 10,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 6,
    parameter int OUT_SHL   = 6,
    parameter int OUT_W     = 16
) (
    input  logic           MCLK,
    input  logic           reset_n,
    md_audio_mix_if.slave  bus
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ACC_W = IN_W + GAIN_W + $clog2(N_CH) + OUT_SHL + 1;
    localparam logic [GAIN_W-1:0] L_UNITY = GAIN_W'(1 << GAIN_FRAC);
    localparam logic [IN_W-1:0]   L_OFS   = {1'b1, {(IN_W-1){1'b0}}};

    state_t                  r_state;
    logic [CH_W-1:0]         r_idx;
    logic signed [IN_W-1:0]  r_hold [N_CH];
    logic signed [IN_W-1:0]  r_snap [N_CH];
    logic [GAIN_W-1:0]       r_gain [N_CH];
    logic [1:0]              r_pan  [N_CH];
    logic signed [OUT_W-1:0] r_out_l;
    logic signed [OUT_W-1:0] r_out_r;
    logic                    r_valid;
    logic                    r_clip;
    logic                    r_overrun;

    logic signed [IN_W-1:0]  w_hold_nxt [N_CH];
    logic                    w_idle;
    logic                    w_start;
    logic                    w_cfg_wr;
    logic signed [ACC_W-1:0] w_acc_l;
    logic signed [ACC_W-1:0] w_acc_r;
    logic signed [ACC_W-1:0] w_v_l;
    logic signed [ACC_W-1:0] w_v_r;
    logic signed [OUT_W-1:0] w_sat_l;
    logic signed [OUT_W-1:0] w_sat_r;
    logic                    w_clip_set;
    logic                    w_ovr_set;

    // Offset-binary sources become two's complement by flipping the MSB.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_hold_nxt[k] = r_hold[k];
            if (bus.ch_valid[k]) begin
                if (bus.ch_unsigned[k])
                    w_hold_nxt[k] = $signed(bus.ch_data[k*IN_W +: IN_W] ^ L_OFS);
                else
                    w_hold_nxt[k] = $signed(bus.ch_data[k*IN_W +: IN_W]);
            end
        end
    end

    assign w_idle    = (r_state == IDLE);
    assign w_start   = w_idle & bus.tick;
    assign w_ovr_set = bus.tick & ~w_idle;
    assign w_cfg_wr  = bus.cfg_we & w_idle & ({1'b0, bus.cfg_ch} < (CH_W+1)'(N_CH));

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_CH; k++)
                r_hold[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++)
                r_hold[k] <= w_hold_nxt[k];
        end
    end

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_CH; k++) begin
                r_gain[k] <= L_UNITY;
                r_pan[k]  <= 2'b11;
            end
        end else if (w_cfg_wr) begin
            r_gain[bus.cfg_ch] <= bus.cfg_gain;
            r_pan[bus.cfg_ch]  <= bus.cfg_pan;
        end
    end

    md_audio_mac #(
        .IN_W   (IN_W),
        .GAIN_W (GAIN_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (MCLK),
        .rst_n    (reset_n),
        .i_clr    (w_start),
        .i_en     (r_state == SUM),
        .i_sample (r_snap[r_idx]),
        .i_gain   (r_gain[r_idx]),
        .i_pan    (r_pan[r_idx]),
        .o_acc_l  (w_acc_l),
        .o_acc_r  (w_acc_r)
    );

    // Accumulator carries OUT_SHL bits of headroom, so the left shift cannot wrap.
    assign w_v_l      = (w_acc_l <<< OUT_SHL) >>> GAIN_FRAC;
    assign w_v_r      = (w_acc_r <<< OUT_SHL) >>> GAIN_FRAC;
    assign w_sat_l    = OUT_W'(sat_s(64'(w_v_l), OUT_W));
    assign w_sat_r    = OUT_W'(sat_s(64'(w_v_r), OUT_W));
    assign w_clip_set = (r_state == SAT) &
                        ((64'(w_sat_l) != 64'(w_v_l)) | (64'(w_sat_r) != 64'(w_v_r)));

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_out_l   <= '0;
            r_out_r   <= '0;
            r_valid   <= 1'b0;
            r_clip    <= 1'b0;
            r_overrun <= 1'b0;
            for (int k = 0; k < N_CH; k++)
                r_snap[k] <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.tick) begin
                        for (int k = 0; k < N_CH; k++)
                            r_snap[k] <= w_hold_nxt[k];
                        r_idx   <= '0;
                        r_state <= SUM;
                    end
                end
                SUM: begin
                    if (r_idx == CH_W'(N_CH - 1))
                        r_state <= SAT;
                    else
                        r_idx <= r_idx + CH_W'(1);
                end
                SAT: begin
                    r_out_l <= w_sat_l;
                    r_out_r <= w_sat_r;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_clip_set)
                r_clip <= 1'b1;
            else if (bus.flag_clr)
                r_clip <= 1'b0;

            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (bus.flag_clr)
                r_overrun <= 1'b0;
        end
    end

    assign bus.out_l     = r_out_l;
    assign bus.out_r     = r_out_r;
    assign bus.out_valid = r_valid;
    assign bus.busy      = ~w_idle;
    assign bus.cfg_ready = w_idle;
    assign bus.clip      = r_clip;
    assign bus.overrun   = r_overrun;
endmodule
